// File: rtl/md_pkg.sv
// md_pkg: shared md_op encodings and default busy-cycle counts for the multiply/divide unit
package md_pkg;
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
endpackage

// File: rtl/md_datapath.sv
// md_datapath: combinational signed/unsigned 32x32 multiply and divide producing {hi_res, lo_res, div_by_zero}
module md_datapath
  import md_pkg::*;
(
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        div_by_zero
);
  logic        sgn, is_div, na, nb;
  logic [63:0] prod;
  logic [31:0] ua, ub, q, r;
  always_comb begin
    sgn         = md_op == MD_MULT || md_op == MD_DIV;
    is_div      = md_op == MD_DIV || md_op == MD_DIVU;
    na          = sgn & a[31];
    nb          = sgn & b[31];
    prod        = {{32{na}}, a} * {{32{nb}}, b};
    div_by_zero = b == 32'd0;
    ua          = na ? -a : a;
    ub          = div_by_zero ? 32'd1 : nb ? -b : b;
    q           = ua / ub;
    r           = ua % ub;
    hi_res      = is_div ? (na ? -r : r) : prod[63:32];
    lo_res      = is_div ? (na ^ nb ? -q : q) : prod[31:0];
  end
endmodule

// File: rtl/md_unit.sv
// md_unit: MIPS EX-stage multiply/divide unit holding HI/LO; in start/md_op/a/b, out busy/hi/lo
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  if (MULT_CYCLES < 1 || MULT_CYCLES > 15 || DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_cycles
    $error("md_unit: MULT_CYCLES and DIV_CYCLES must be in 1..15");
  end
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d, pdz_q, pdz_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, phi_q, phi_d, plo_q, plo_d;
  logic [31:0] hi_res, lo_res;
  logic        dz, accept, is_mul, is_div, load, commit;
  md_datapath u_dp (
    .md_op       (md_op),
    .a           (a),
    .b           (b),
    .hi_res      (hi_res),
    .lo_res      (lo_res),
    .div_by_zero (dz)
  );
  always_comb begin
    accept = start && cnt_q == 4'd0;
    is_mul = md_op == MD_MULT || md_op == MD_MULTU;
    is_div = md_op == MD_DIV || md_op == MD_DIVU;
    load   = accept && (is_mul || is_div);
    commit = cnt_q == 4'd1 && !pdz_q;
    cnt_d  = load ? (is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES)) : cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
    busy_d = cnt_d != 4'd0;
    phi_d  = load ? hi_res : phi_q;
    plo_d  = load ? lo_res : plo_q;
    pdz_d  = load ? is_div && dz : pdz_q;
    hi_d   = commit ? phi_q : accept && md_op == MD_MTHI ? a : hi_q;
    lo_d   = commit ? plo_q : accept && md_op == MD_MTLO ? a : lo_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 4'd0;
      busy_q <= 1'b0;
      pdz_q  <= 1'b0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      phi_q  <= 32'd0;
      plo_q  <= 32'd0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      pdz_q  <= pdz_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      phi_q  <= phi_d;
      plo_q  <= plo_d;
    end
  end
  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed and randomized checks of md_unit against an arithmetic HI/LO model
module tb_md_unit;
  import md_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic [31:0] hi, lo;
  int          vectors = 0;
  int          miscompares = 0;
  int          viol = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  md_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .md_op (md_op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (rst_n && start && busy) begin
      viol++;
      $display("note: start asserted while busy at %0t (protocol violation, must be ignored)", $time);
    end
  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] x, y, h, l);
    longint p, q, r;
    case (op)
      3'd0: begin
        p = longint'($signed(x)) * longint'($signed(y));
        return 64'(p);
      end
      3'd1: return {32'd0, x} * {32'd0, y};
      3'd2: begin
        if (y == 0) return {h, l};
        q = longint'($signed(x)) / longint'($signed(y));
        r = longint'($signed(x)) % longint'($signed(y));
        return {r[31:0], q[31:0]};
      end
      3'd3: return y == 0 ? {h, l} : {x % y, x / y};
      3'd4: return {x, l};
      3'd5: return {h, x};
      default: return {h, l};
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic do_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y, input int glitch_at);
    logic [63:0] r;
    int n, n_exp;
    r = ref_md(op, x, y, m_hi, m_lo);
    n_exp = op <= 3'd1 ? 5 : op <= 3'd3 ? 10 : 0;
    start = 1'b1;
    md_op = op;
    a = x;
    b = y;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      chk("hold_hi", hi, m_hi);
      chk("hold_lo", lo, m_lo);
      if (n == glitch_at) begin
        start = 1'b1;
        md_op = MD_MULT;
        a = $urandom;
        b = $urandom;
      end
      @(negedge clk);
      start = 1'b0;
    end
    chk("busy_len", 32'(n), 32'(n_exp));
    m_hi = r[63:32];
    m_lo = r[31:0];
    chk("res_hi", hi, m_hi);
    chk("res_lo", lo, m_lo);
  endtask
  initial begin
    logic [2:0]  op;
    logic [31:0] x, y;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(MD_MTHI, 32'hDEADBEEF, 32'h0, 0);
    chk("mthi_hi", hi, 32'hDEADBEEF);
    chk("mthi_lo", lo, 32'd0);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    do_op(MD_MULT, 32'hFFFFFFFF, 32'h2, 0);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFE);
    do_op(MD_MULTU, 32'hFFFFFFFF, 32'h2, 0);
    chk("multu_hi", hi, 32'h00000001);
    chk("multu_lo", lo, 32'hFFFFFFFE);
    do_op(MD_DIV, 32'hFFFFFFF9, 32'h2, 0);
    chk("div_hi", hi, 32'hFFFFFFFF);
    chk("div_lo", lo, 32'hFFFFFFFD);
    do_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 0);
    chk("divovf_hi", hi, 32'h0);
    chk("divovf_lo", lo, 32'h80000000);
    do_op(MD_DIVU, 32'd100, 32'd7, 0);
    chk("divu_hi", hi, 32'd2);
    chk("divu_lo", lo, 32'd14);
    do_op(MD_MTHI, 32'h11, 32'h0, 0);
    do_op(MD_MTLO, 32'h22, 32'h0, 0);
    do_op(MD_DIVU, 32'd1234, 32'd0, 0);
    chk("dz_hi", hi, 32'h11);
    chk("dz_lo", lo, 32'h22);
    do_op(3'd6, 32'hAAAA5555, 32'h1, 0);
    chk("rsvd_hi", hi, 32'h11);
    do_op(MD_MULT, 32'd1000, 32'hFFFFFFFD, 2);
    chk("protocol_viol", 32'(viol), 32'd1);
    do_op(MD_MULT, 32'd7, 32'd9, 0);
    chk("b2b_lo", lo, 32'd63);
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 6));
      x = $urandom;
      y = $urandom_range(0, 7) == 0 ? 32'd0 : $urandom_range(0, 3) == 0 ? 32'($urandom_range(1, 20)) : $urandom;
      if ($urandom_range(0, 3) == 0) y = -y;
      do_op(op, x, y, 0);
    end
    do_op(MD_MTHI, 32'h55, 32'h0, 0);
    start = 1'b1;
    md_op = MD_DIV;
    a = 32'd1000;
    b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_hi", hi, 32'd0);
    chk("async_lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
    end
    chk("post_rst_hi", hi, 32'd0);
    chk("post_rst_lo", lo, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
Multiply/divide unit in the EX stage of the five-stage MIPS pipeline. It executes mult, multu, div, divu, mthi and mtlo, and holds the architectural HI/LO registers. It drives `busy` to the hazard/stall unit, which holds any md/mf/mt instruction in D while `busy` is high or an md op sits in E. HI/LO feed the mfhi/mflo result mux in E.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  E-stage instruction is an md/mt op, qualified by pipeline valid (not flushed)
md_op  in  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo, 6..7 reserved
a  in  32  forwarded rs operand (E stage)
b  in  32  forwarded rt operand (E stage)
busy  out  1  operation in progress; HI/LO not yet valid
hi  out  32  HI register
lo  out  32  LO register

Behaviour:
- Reset (async, rst_n=0): hi=0, lo=0, busy=0, counter=0, pending results=0. Outputs take these values immediately, not at the next edge.
- States: IDLE (counter=0) and RUN (counter>0). busy = (counter != 0), driven straight from a register.
- Accept rule: start is accepted only in IDLE. While busy, start is ignored. The stall unit guarantees start never arrives while busy; the bench flags a violation if it does.
- mult/multu/div/divu accepted at edge T:
  - Operands are captured and the 64-bit result is computed into pending registers. The counter loads N (MULT_CYCLES or DIV_CYCLES).
  - busy is high from cycle T+1 through T+N.
  - At the edge ending cycle T+N, pending values are committed to hi/lo and the counter reaches 0.
  - New hi/lo are visible in the same cycle busy falls.
- mult: signed 32x32 to 64; hi = product[63:32], lo = product[31:0]. multu: unsigned.
- div: signed; lo = quotient truncated toward zero; hi = remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: unsigned.
- Divide by zero (b==0, div or divu): full DIV_CYCLES busy; hi/lo left unchanged at commit.
- mthi/mtlo: a is written to hi or lo at the accept edge. busy stays 0 and the other register is untouched.
- Reserved md_op with start: no effect, no busy.
- Reset mid-operation aborts the operation. No commit occurs after rst_n is released; the unit starts in IDLE.
- Counter width is 4 bits; parameters above 15 are illegal (elaboration-time check).
- hi/lo change only at a commit, an mt write, or reset. Between those events they are stable.

Decomposition:
- Shared package md_pkg holds:
  - md_op encodings: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
  - Default MULT_CYCLES and DIV_CYCLES.
- The same package is imported by the E-stage decoder that generates start/md_op, so the encodings stay consistent.
- One sub-module, md_datapath: combinational signed/unsigned multiply and divide returning {hi_res, lo_res, div_by_zero}.
- md_unit keeps the counter, pending registers and HI/LO.

Test Plan:
- Reset: hold rst_n=0 mid-RUN (3 cycles into a div), release -> busy=0, hi=lo=0, no later commit.
- Signed and unsigned multiply:
  - mult a=0xFFFFFFFF b=0x00000002 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- Signed divide:
  - div a=0xFFFFFFF9 (-7) b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Unsigned divide and divide by zero:
  - divu a=100 b=7 -> lo=14, hi=2.
  - Preload hi=0x11, lo=0x22 via mthi/mtlo, then divu b=0 -> busy 10 cycles, hi=0x11, lo=0x22 unchanged.
- Moves and ignored starts:
  - mthi a=0xDEADBEEF -> hi updated next cycle, busy never asserts, lo unchanged.
  - start pulse with mult during RUN -> ignored; original result commits on schedule and the bench flags the assertion.
- Back-to-back: mult accepted the cycle after busy falls -> previous hi/lo readable in that cycle, new result after 5 more busy cycles.
